// File: rtl/palette_lookup.sv
// palette_lookup
// Turns a stream of 8-bit colour indices into 12-bit RGB through the
// external 256x16 palette RAM. Two stages: S1 holds the accepted index while
// the RAM read is in flight, and S2 holds the output pixel. Both sides use
// valid/ready handshakes, and the block runs at one pixel per clock.
module palette_lookup (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        pix_valid_i,
   output logic        pix_ready_o,
   input  logic [7:0]  pix_idx_i,
   input  logic        pix_blank_i,
   input  logic [3:0]  pal_offset_i,
   output logic [7:0]  pal_rd_addr_o,
   input  logic [15:0] pal_rd_data_i,
   output logic        rgb_valid_o,
   input  logic        rgb_ready_i,
   output logic [11:0] rgb_o,
   output logic        rgb_blank_o,
   output logic        underrun_o,
   input  logic        underrun_clr_i
);

   logic        s1Valid_q, s1Valid_d;
   logic [7:0]  s1Idx_q, s1Idx_d;
   logic        s1Blank_q, s1Blank_d;
   logic        rgbValid_q, rgbValid_d;
   logic [11:0] rgb_q, rgb_d;
   logic        rgbBlank_q, rgbBlank_d;
   logic        underrun_q, underrun_d;
   logic        seenPixel_q, seenPixel_d;

   logic [7:0]  effIdx;
   logic        advance;
   logic        accept;
   logic        unusedDataBits;

   // The upper nibble of each palette word carries no colour information.
   assign unusedDataBits = ^pal_rd_data_i[15:12];

   // Compute the effective index and the handshake terms, then choose the RAM
   // address. Index 0 is always black and never moves with the offset. An
   // accepted pixel starts its read right away. During a stall the address
   // stays on the held S1 entry, so the RAM keeps re-reading that entry.
   always_comb begin
      effIdx        = (pix_idx_i == 8'h00) ? 8'h00 : (pix_idx_i + {pal_offset_i, 4'h0});
      advance       = s1Valid_q & (~rgbValid_q | rgb_ready_i);
      pix_ready_o   = rst_n_i & (~s1Valid_q | advance);
      accept        = pix_valid_i & pix_ready_o;
      pal_rd_addr_o = accept ? effIdx : s1Idx_q;
   end

   // S1 next state. A new pixel overwrites S1 even on the edge where the old
   // S1 pixel moves into S2. This is what allows one pixel per clock.
   always_comb begin
      s1Valid_d = s1Valid_q;
      s1Idx_d   = s1Idx_q;
      s1Blank_d = s1Blank_q;
      if (accept) begin
         s1Valid_d = 1'b1;
         s1Idx_d   = effIdx;
         s1Blank_d = pix_blank_i;
      end else if (advance) begin
         s1Valid_d = 1'b0;
      end
   end

   // S2 next state. It captures the RAM data when S1 advances. When S2 empties
   // only the valid flag drops. The colour holds, so the output stays steady
   // while downstream stalls.
   always_comb begin
      rgbValid_d = rgbValid_q;
      rgb_d      = rgb_q;
      rgbBlank_d = rgbBlank_q;
      if (advance) begin
         rgbValid_d = 1'b1;
         rgb_d      = s1Blank_q ? 12'h000 : pal_rd_data_i[11:0];
         rgbBlank_d = s1Blank_q;
      end else if (rgbValid_q & rgb_ready_i) begin
         rgbValid_d = 1'b0;
      end
   end

   // Underrun flag. It only counts once a pixel has been produced since reset,
   // so the idle period after reset is not flagged. A clear in the same cycle
   // as a new underrun wins.
   always_comb begin
      seenPixel_d = seenPixel_q | advance;
      underrun_d  = underrun_q;
      if (underrun_clr_i) begin
         underrun_d = 1'b0;
      end else if (rgb_ready_i & ~rgbValid_q & seenPixel_q) begin
         underrun_d = 1'b1;
      end
   end

   // State registers with synchronous active-low reset. Reset drops any pixels
   // still in flight.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         s1Valid_q   <= 1'b0;
         s1Idx_q     <= 8'h00;
         s1Blank_q   <= 1'b0;
         rgbValid_q  <= 1'b0;
         rgb_q       <= 12'h000;
         rgbBlank_q  <= 1'b0;
         underrun_q  <= 1'b0;
         seenPixel_q <= 1'b0;
      end else begin
         s1Valid_q   <= s1Valid_d;
         s1Idx_q     <= s1Idx_d;
         s1Blank_q   <= s1Blank_d;
         rgbValid_q  <= rgbValid_d;
         rgb_q       <= rgb_d;
         rgbBlank_q  <= rgbBlank_d;
         underrun_q  <= underrun_d;
         seenPixel_q <= seenPixel_d;
      end
   end

   assign rgb_valid_o = rgbValid_q;
   assign rgb_o       = rgb_q;
   assign rgb_blank_o = rgbBlank_q;
   assign underrun_o  = underrun_q;

endmodule

// File: tb/tb_palette_lookup.sv
// tb_palette_lookup
// Bench for palette_lookup. It contains a behavioural palette RAM and a
// transaction-level model that tracks pixels in flight, expected colours and
// the underrun flag. The model is checked every cycle, and literal
// expectations pin the model down.
module tb_palette_lookup;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        pix_valid_i;
   logic        pix_ready_o;
   logic [7:0]  pix_idx_i;
   logic        pix_blank_i;
   logic [3:0]  pal_offset_i;
   logic [7:0]  pal_rd_addr_o;
   logic [15:0] pal_rd_data_i;
   logic        rgb_valid_o;
   logic        rgb_ready_i;
   logic [11:0] rgb_o;
   logic        rgb_blank_o;
   logic        underrun_o;
   logic        underrun_clr_i;

   int testsRun  = 0;
   int failCount = 0;

   palette_lookup dut (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .pix_valid_i    (pix_valid_i),
      .pix_ready_o    (pix_ready_o),
      .pix_idx_i      (pix_idx_i),
      .pix_blank_i    (pix_blank_i),
      .pal_offset_i   (pal_offset_i),
      .pal_rd_addr_o  (pal_rd_addr_o),
      .pal_rd_data_i  (pal_rd_data_i),
      .rgb_valid_o    (rgb_valid_o),
      .rgb_ready_i    (rgb_ready_i),
      .rgb_o          (rgb_o),
      .rgb_blank_o    (rgb_blank_o),
      .underrun_o     (underrun_o),
      .underrun_clr_i (underrun_clr_i)
   );

   // Free-running clock
   always #5 clk_i = ~clk_i;

   // Behavioural palette RAM with a one-cycle registered read
   logic [15:0] palMem [256];
   always @(posedge clk_i) pal_rd_data_i <= palMem[pal_rd_addr_o];

   typedef struct {
      logic [7:0]  eff;
      logic        blank;
      int          acc;
      logic        shown;
      logic [11:0] val;
   } pixItem_t;

   typedef struct {
      logic [11:0] rgb;
      logic        blank;
   } outRec_t;

   pixItem_t    modelQ[$];
   outRec_t     outLog[$];
   int          cyc         = 0;
   bit          seenAny     = 0;
   bit          expUnderrun = 0;
   bit          prevStall   = 0;
   logic [11:0] prevRgb;
   logic        prevBlank;
   logic [7:0]  lastAddr;

   function automatic logic [7:0] effOf(input logic [7:0] idx, input logic [3:0] off);
      if (idx == 8'h00) return 8'h00;
      return 8'((int'(idx) + int'(off) * 16) % 256);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model and per-cycle compare. Pixels are tracked in order. The
   // oldest pixel becomes visible one full edge after it is accepted. A
   // pixel's colour is the palette entry as it stands when the pixel is
   // presented.
   always @(negedge clk_i) begin
      logic       expValid;
      logic       expReady;
      logic       accNow;
      logic       haveAddr;
      logic [7:0] expAddr;
      pixItem_t   item;
      outRec_t    rec;
      expValid = (modelQ.size() > 0) && (modelQ[0].acc <= cyc - 2);
      if (expValid && !modelQ[0].shown) begin
         item       = modelQ[0];
         item.shown = 1'b1;
         item.val   = item.blank ? 12'h000 : palMem[item.eff][11:0];
         modelQ[0]  = item;
         seenAny    = 1;
      end
      checkOutput("rgb_valid", 32'(rgb_valid_o), 32'(expValid));
      if (expValid) begin
         checkOutput("rgb", 32'(rgb_o), 32'(modelQ[0].val));
         checkOutput("rgb_blank", 32'(rgb_blank_o), 32'(modelQ[0].blank));
      end
      if (prevStall) begin
         checkOutput("stall_rgb_stable", 32'(rgb_o), 32'(prevRgb));
         checkOutput("stall_blank_stable", 32'(rgb_blank_o), 32'(prevBlank));
      end
      checkOutput("underrun", 32'(underrun_o), 32'(expUnderrun));
      expReady = rst_n_i && !(modelQ.size() == 2 && !rgb_ready_i);
      checkOutput("pix_ready", 32'(pix_ready_o), 32'(expReady));
      accNow   = pix_valid_i && expReady;
      haveAddr = 1'b0;
      expAddr  = 8'h00;
      if (accNow) begin
         haveAddr = 1'b1;
         expAddr  = effOf(pix_idx_i, pal_offset_i);
      end else if (rst_n_i && modelQ.size() == 2) begin
         haveAddr = 1'b1;
         expAddr  = modelQ[1].eff;
      end else if (rst_n_i && modelQ.size() == 1 && !expValid) begin
         haveAddr = 1'b1;
         expAddr  = modelQ[0].eff;
      end
      if (haveAddr) checkOutput("rd_addr", 32'(pal_rd_addr_o), 32'(expAddr));
      if (!rst_n_i) begin
         modelQ.delete();
         seenAny     = 0;
         expUnderrun = 0;
      end else begin
         if (underrun_clr_i) expUnderrun = 0;
         else if (rgb_ready_i && !expValid && seenAny) expUnderrun = 1;
         if (expValid && rgb_ready_i) begin
            rec.rgb   = rgb_o;
            rec.blank = rgb_blank_o;
            outLog.push_back(rec);
            void'(modelQ.pop_front());
         end
         if (accNow) begin
            item.eff   = effOf(pix_idx_i, pal_offset_i);
            item.blank = pix_blank_i;
            item.acc   = cyc;
            item.shown = 1'b0;
            item.val   = 12'h000;
            modelQ.push_back(item);
         end
      end
      prevStall = rst_n_i && expValid && !rgb_ready_i;
      prevRgb   = rgb_o;
      prevBlank = rgb_blank_o;
      cyc++;
   end

   // Offers one pixel and waits, with a bound, for it to be accepted
   task automatic applyStimulus(input logic [7:0] idx, input logic blank, input logic [3:0] off);
      pix_valid_i  = 1'b1;
      pix_idx_i    = idx;
      pix_blank_i  = blank;
      pal_offset_i = off;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk_i);
         if (pix_ready_o) begin
            lastAddr = pal_rd_addr_o;
            @(posedge clk_i);
            #1;
            return;
         end
      end
      checkOutput("accept_timeout", 32'(0), 32'(1));
   endtask

   task automatic idleCycles(input int n);
      pix_valid_i = 1'b0;
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   // Watchdog
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence
   initial begin
      bit t4Done;
      for (int i = 0; i < 256; i++) palMem[i] = {4'hA, 12'((i * 37 + 5) % 4096)};
      palMem[0]  = 16'hF000; palMem[1]  = 16'hFFFF; palMem[2]  = 16'hF800; palMem[3]  = 16'hFAFE;
      palMem[4]  = 16'hF0F0; palMem[5]  = 16'hF00F; palMem[6]  = 16'hFF00; palMem[7]  = 16'hF123;
      palMem[8]  = 16'hF456; palMem[9]  = 16'hF789; palMem[10] = 16'hFABC; palMem[11] = 16'hFDEF;
      palMem[12] = 16'hF321; palMem[13] = 16'hF654; palMem[14] = 16'hF987; palMem[15] = 16'hFBBB;
      rst_n_i = 1'b0; pix_valid_i = 1'b0; pix_idx_i = 8'h00; pix_blank_i = 1'b0;
      pal_offset_i = 4'h0; rgb_ready_i = 1'b1; underrun_clr_i = 1'b0;

      // Reset state
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      checkOutput("reset_pix_ready", 32'(pix_ready_o), 32'(0));
      @(posedge clk_i); #1 rst_n_i = 1'b1;
      @(negedge clk_i);
      checkOutput("reset_valid", 32'(rgb_valid_o), 32'(0));
      checkOutput("reset_rgb", 32'(rgb_o), 32'(0));
      checkOutput("reset_blank", 32'(rgb_blank_o), 32'(0));
      checkOutput("reset_underrun", 32'(underrun_o), 32'(0));
      idleCycles(3);
      checkOutput("underrun_noseen", 32'(underrun_o), 32'(0));

      // Latency of the first pixel, then the default palette sequence
      applyStimulus(8'h00, 1'b0, 4'h0);
      pix_valid_i = 1'b0;
      @(negedge clk_i);
      checkOutput("lat_after_e0", 32'(rgb_valid_o), 32'(0));
      @(negedge clk_i);
      checkOutput("lat_after_e1", 32'(rgb_valid_o), 32'(1));
      checkOutput("lat_rgb", 32'(rgb_o), 32'(12'h000));
      idleCycles(2);
      outLog.delete();
      for (int i = 0; i < 16; i++) applyStimulus(8'(i), 1'b0, 4'h0);
      idleCycles(4);
      checkOutput("t1_count", 32'(outLog.size()), 32'(16));
      if (outLog.size() == 16) begin
         checkOutput("t1_idx1", 32'(outLog[1].rgb), 32'(12'hFFF));
         checkOutput("t1_idx2", 32'(outLog[2].rgb), 32'(12'h800));
         checkOutput("t1_idx3", 32'(outLog[3].rgb), 32'(12'hAFE));
         checkOutput("t1_idx15", 32'(outLog[15].rgb), 32'(12'hBBB));
      end

      // Offset handling: a plain offset, index 0 exempt from the offset, and wraparound
      outLog.delete();
      applyStimulus(8'h01, 1'b0, 4'h2);
      checkOutput("t2_addr_21", 32'(lastAddr), 32'(8'h21));
      applyStimulus(8'h00, 1'b0, 4'h2);
      checkOutput("t2_addr_00", 32'(lastAddr), 32'(8'h00));
      applyStimulus(8'hF5, 1'b0, 4'h1);
      checkOutput("t2_addr_05", 32'(lastAddr), 32'(8'h05));
      idleCycles(4);
      if (outLog.size() == 3) begin
         checkOutput("t2_rgb_21", 32'(outLog[0].rgb), 32'(12'h4CA));
         checkOutput("t2_rgb_00", 32'(outLog[1].rgb), 32'(12'h000));
         checkOutput("t2_rgb_05", 32'(outLog[2].rgb), 32'(12'h00F));
      end else checkOutput("t2_count", 32'(outLog.size()), 32'(3));

      // Blanking pixel followed by a normal pixel
      outLog.delete();
      applyStimulus(8'h01, 1'b1, 4'h0);
      applyStimulus(8'h01, 1'b0, 4'h0);
      idleCycles(4);
      if (outLog.size() == 2) begin
         checkOutput("t3_blank_rgb", 32'(outLog[0].rgb), 32'(12'h000));
         checkOutput("t3_blank_flag", 32'(outLog[0].blank), 32'(1));
         checkOutput("t3_next_rgb", 32'(outLog[1].rgb), 32'(12'hFFF));
         checkOutput("t3_next_flag", 32'(outLog[1].blank), 32'(0));
      end else checkOutput("t3_count", 32'(outLog.size()), 32'(2));

      // Random downstream backpressure over 64 pixels
      outLog.delete();
      t4Done = 0;
      fork
         begin
            for (int i = 0; i < 64; i++)
               applyStimulus(8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
            pix_valid_i = 1'b0;
            t4Done = 1;
         end
         begin
            while (!t4Done) begin
               @(posedge clk_i);
               #1 rgb_ready_i = ($urandom_range(0, 3) != 0);
            end
         end
      join
      rgb_ready_i = 1'b1;
      idleCycles(4);
      checkOutput("t4_count", 32'(outLog.size()), 32'(64));

      // Stall with two pixels held, then rewrite the entry held in S1
      outLog.delete();
      fork
         begin
            for (int i = 0; i < 6; i++) applyStimulus(8'h40 + 8'(i), 1'b0, 4'h0);
            pix_valid_i = 1'b0;
         end
         begin
            for (int n = 0; n < 50 && outLog.size() < 3; n++) @(posedge clk_i);
            #1 rgb_ready_i = 1'b0;
            repeat (3) @(posedge clk_i);
            #1 palMem[8'h44] = 16'h75A6;
            repeat (2) @(posedge clk_i);
            #1 rgb_ready_i = 1'b1;
         end
      join
      idleCycles(4);
      if (outLog.size() == 6) begin
         checkOutput("t5_held_s2", 32'(outLog[3].rgb), 32'(12'h9B4));
         checkOutput("t5_rewritten_s1", 32'(outLog[4].rgb), 32'(12'h5A6));
      end else checkOutput("t5_count", 32'(outLog.size()), 32'(6));

      // Reset in the middle of a stream, then starve the input and clear the underrun flag
      fork
         begin
            for (int i = 0; i < 8; i++) applyStimulus(8'h10 + 8'(i), 1'b0, 4'h0);
            pix_valid_i = 1'b0;
         end
         begin
            repeat (3) @(posedge clk_i);
            #1 rst_n_i = 1'b0;
            @(negedge clk_i);
            checkOutput("t6_rst_ready", 32'(pix_ready_o), 32'(0));
            @(posedge clk_i);
            @(negedge clk_i);
            checkOutput("t6_rst_valid", 32'(rgb_valid_o), 32'(0));
            @(posedge clk_i);
            #1 rst_n_i = 1'b1;
         end
      join
      idleCycles(4);
      checkOutput("t6_underrun_set", 32'(underrun_o), 32'(1));
      underrun_clr_i = 1'b1;
      @(posedge clk_i); #1 underrun_clr_i = 1'b0;
      @(negedge clk_i);
      checkOutput("t6_clr_wins", 32'(underrun_o), 32'(0));
      @(negedge clk_i);
      checkOutput("t6_reset_again", 32'(underrun_o), 32'(1));
      @(posedge clk_i); #1 rgb_ready_i = 1'b0; underrun_clr_i = 1'b1;
      @(posedge clk_i); #1 underrun_clr_i = 1'b0;
      idleCycles(2);
      checkOutput("t6_cleared_hold", 32'(underrun_o), 32'(0));

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
